// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier.
// Holds the controller state encoding and the accumulator-width rule.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Wide enough to hold the sum of N full-scale DW x DW products.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Operand/result handshake bundle for matmul_seq.
// The master drives operands and accepts results; the slave is the multiplier.
interface matmul_seq_if #(
    parameter int N  = 3,
    parameter int DW = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*N*DW-1:0]     a_flat;
    logic [N*N*DW-1:0]     b_flat;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*N*DW-1:0]     result;
    logic                  busy;

    modport master (
        output in_valid, a_flat, b_flat, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a_flat, b_flat, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate with synchronous clear, plus the reduced
// element value of the next sum (saturating when MATMUL_SEQ_SAT_EN is defined).
module matmul_mac #(
    parameter int DW = 8,
    parameter int AW = 2 * DW + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_elem
);

    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   w_sum;
    logic [2*DW-1:0] w_prod;

    assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
    assign w_sum  = r_acc + {{(AW-2*DW){1'b0}}, w_prod};

    // Clear wins over enable so the last product of an element never leaks
    // into the next element's sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

    always_comb begin
`ifdef MATMUL_SEQ_SAT_EN
        o_elem = (|w_sum[AW-1:DW]) ? {DW{1'b1}} : w_sum[DW-1:0];
`else
        o_elem = w_sum[DW-1:0];
`endif
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier, one MAC per cycle (k inner, j, i outer).
// Optional feature: define MATMUL_SEQ_SAT_EN to clamp elements instead of wrapping.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    matmul_seq_if.slave io_bus
);

    localparam int NE = N * N;
    localparam int AW = acc_width(N, DW);
    localparam int IW = idx_width(N);

    state_t            r_state;
    state_t            w_next;
    logic [NE*DW-1:0]  r_a;
    logic [NE*DW-1:0]  r_b;
    logic [NE*DW-1:0]  r_res;
    logic [NE*DW-1:0]  r_result;
    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_j;
    logic [IW-1:0]     r_k;
    logic              r_fin;

    logic              w_accept;
    logic              w_step;
    logic              w_last_i;
    logic              w_last_j;
    logic              w_last_k;
    logic              w_wr_elem;
    logic              w_mac_clr;
    logic [DW-1:0]     w_a_elem;
    logic [DW-1:0]     w_b_elem;
    logic [DW-1:0]     w_elem;

    // Element [row][col] sits MSB-first in the flat vectors.
    function automatic int elem_lsb(input int row, input int col);
        return (NE - 1 - (row * N + col)) * DW;
    endfunction

    assign w_accept  = io_bus.in_valid && (r_state == IDLE);
    assign w_step    = (r_state == COMPUTE) && !r_fin;
    assign w_last_i  = (r_i == IW'(N - 1));
    assign w_last_j  = (r_j == IW'(N - 1));
    assign w_last_k  = (r_k == IW'(N - 1));
    assign w_wr_elem = w_step && w_last_k;
    assign w_mac_clr = w_accept || w_wr_elem;

    assign w_a_elem = r_a[elem_lsb(int'(r_i), int'(r_k)) +: DW];
    assign w_b_elem = r_b[elem_lsb(int'(r_k), int'(r_j)) +: DW];

    matmul_mac #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_mac_clr),
        .i_en    (w_step),
        .i_a     (w_a_elem),
        .i_b     (w_b_elem),
        .o_elem  (w_elem)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (io_bus.in_valid)  w_next = COMPUTE;
            COMPUTE: if (r_fin)            w_next = DONE;
            DONE:    if (io_bus.out_ready) w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    // Loop indices; r_fin marks that the final MAC has been written back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_fin <= 1'b0;
        end else if (w_accept) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_fin <= 1'b0;
        end else if (w_step) begin
            if (w_last_k) begin
                r_k <= '0;
                if (w_last_j) begin
                    r_j <= '0;
                    if (w_last_i) begin
                        r_fin <= 1'b1;
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end else begin
                    r_j <= r_j + IW'(1);
                end
            end else begin
                r_k <= r_k + IW'(1);
            end
        end
    end

    // NOTE: operand and scratch storage carry no reset: each is fully
    // written by a job before it is read, and only r_result is visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= io_bus.a_flat;
            r_b <= io_bus.b_flat;
        end
        if (w_wr_elem) begin
            r_res[elem_lsb(int'(r_i), int'(r_j)) +: DW] <= w_elem;
        end
    end

    // The visible result only changes on the COMPUTE -> DONE transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if ((r_state == COMPUTE) && r_fin) begin
            r_result <= r_res;
        end
    end

    assign io_bus.in_ready  = (r_state == IDLE);
    assign io_bus.busy      = (r_state == COMPUTE);
    assign io_bus.out_valid = (r_state == DONE);
    assign io_bus.result    = r_result;

endmodule
